// File: rtl/mips_pkg.sv
// Shared EX-stage definitions: ALUOp encodings driven by ControlUnit, default datapath
// width and the multiplier sequencer states.
package mips_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b100,
        ALU_MUL = 3'b101,
        ALU_NOR = 3'b110,
        ALU_XOR = 3'b111
    } aluOp_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mulState_e;

endpackage

// File: rtl/ex_booth_multiplier_if.sv
// EX-stage multiply bundle: the ID/EX side (master) issues operands and flush,
// the multiplier (slave) returns stall, busy, done and the product.
interface ex_booth_multiplier_if
    import mips_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic                 ex_valid;
    logic [2:0]           alu_op;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic                 flush;
    logic                 stall;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output ex_valid, alu_op, op_a, op_b, flush,
        input  stall, busy, done, product
    );

    modport slave (
        input  ex_valid, alu_op, op_a, op_b, flush,
        output stall, busy, done, product
    );

endinterface

// File: rtl/ex_booth_multiplier_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A selected by {Q[0],Q_1},
// followed by an arithmetic right shift of the {A,Q,Q_1} chain.
module booth_step #(
    parameter int WIDTH = 32
) (
    input  logic signed [WIDTH:0]   aIn,
    input  logic        [WIDTH-1:0] qIn,
    input  logic                    q1In,
    input  logic signed [WIDTH:0]   mIn,
    output logic signed [WIDTH:0]   aOut,
    output logic        [WIDTH-1:0] qOut,
    output logic                    q1Out
);

    logic signed [WIDTH:0] sum;

    always_comb begin
        sum = aIn;
        case ({qIn[0], q1In})
            2'b01:   sum = aIn + mIn;
            2'b10:   sum = aIn - mIn;
            default: sum = aIn;
        endcase
        // Shift the whole chain right by one, replicating the sign of A.
        aOut  = {sum[WIDTH], sum[WIDTH:1]};
        qOut  = {sum[0], qIn[WIDTH-1:1]};
        q1Out = qIn[0];
    end

endmodule

// File: rtl/ex_booth_multiplier.sv
// Sequential radix-2 Booth signed multiplier for the EX stage: holds the pipeline while
// iterating WIDTH steps, then pulses done for one cycle with the 2*WIDTH-bit product.
module ex_booth_multiplier
    import mips_pkg::*;
#(
    parameter int         WIDTH     = DEFAULT_WIDTH,
    parameter logic [2:0] ALUOP_MUL = ALU_MUL
) (
    input  logic                  clk,
    input  logic                  rst,
    ex_booth_multiplier_if.slave  bus
);

    localparam int                CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    mulState_e             state;
    logic [CNT_W-1:0]      count;
    logic                  doneReg;
    logic [2*WIDTH-1:0]    productReg;

    logic signed [WIDTH:0] aReg;
    logic signed [WIDTH:0] mReg;
    logic [WIDTH-1:0]      qReg;
    logic                  q1Reg;

    logic signed [WIDTH:0] stepA;
    logic [WIDTH-1:0]      stepQ;
    logic                  stepQ1;
    logic                  start;

    // Gated by rst so stall is already low while reset is held.
    assign start = !rst && bus.ex_valid && (bus.alu_op == ALUOP_MUL) && !bus.flush
                   && (state == IDLE);

    assign bus.stall   = start || ((state == RUN) && !bus.flush);
    assign bus.busy    = (state != IDLE);
    assign bus.done    = doneReg;
    assign bus.product = productReg;

    booth_step #(.WIDTH(WIDTH)) u_step (
        .aIn   (aReg),
        .qIn   (qReg),
        .q1In  (q1Reg),
        .mIn   (mReg),
        .aOut  (stepA),
        .qOut  (stepQ),
        .q1Out (stepQ1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            doneReg    <= 1'b0;
            productReg <= '0;
        end else begin
            doneReg <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= RUN;
                        count <= '0;
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        count <= count + 1'b1;
                        if (count == LAST_CNT) begin
                            state      <= DONE;
                            doneReg    <= 1'b1;
                            productReg <= {stepA[WIDTH-1:0], stepQ};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Operand/accumulator chain carries no control meaning, so it is left unreset.
    always_ff @(posedge clk) begin
        if (start) begin
            aReg  <= '0;
            qReg  <= bus.op_b;
            q1Reg <= 1'b0;
            mReg  <= {bus.op_a[WIDTH-1], bus.op_a};
        end else if (state == RUN) begin
            aReg  <= stepA;
            qReg  <= stepQ;
            q1Reg <= stepQ1;
        end
    end

endmodule

// File: tb/tb_ex_booth_multiplier.sv
// Self-checking bench for ex_booth_multiplier: cycle-level behavioural model plus directed
// literal cases, mid-run flush/reset, back-to-back issue and randomized operand pairs.
module tb_ex_booth_multiplier;

    localparam int         WIDTH  = 32;
    localparam logic [2:0] MUL_OP = 3'b101;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    ex_booth_multiplier_if #(.WIDTH(WIDTH)) bus ();

    ex_booth_multiplier #(.WIDTH(WIDTH), .ALUOP_MUL(MUL_OP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 multiplying, 2 result cycle.
    int          mPhase = 0;
    int          mLeft  = 0;
    logic [63:0] mProd  = '0;
    logic [63:0] mPend  = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mPhase <= 0;
            mLeft  <= 0;
            mProd  <= '0;
        end else begin
            case (mPhase)
                0: if (bus.ex_valid && bus.alu_op == MUL_OP && !bus.flush) begin
                    mPhase <= 1;
                    mLeft  <= WIDTH;
                    mPend  <= 64'(longint'(signed'(bus.op_a)) * longint'(signed'(bus.op_b)));
                end
                1: if (bus.flush) mPhase <= 0;
                   else if (mLeft == 1) begin
                       mPhase <= 2;
                       mProd  <= mPend;
                   end else mLeft <= mLeft - 1;
                default: mPhase <= 0;
            endcase
        end
    end

    initial begin
        logic expStall;
        @(posedge rst);
        forever begin
            @(negedge clk);
            expStall = !rst && (((mPhase == 0) && bus.ex_valid && bus.alu_op == MUL_OP && !bus.flush)
                                || ((mPhase == 1) && !bus.flush));
            check("cyc_stall",   64'(bus.stall), 64'(expStall));
            check("cyc_busy",    64'(bus.busy),  64'(mPhase != 0));
            check("cyc_done",    64'(bus.done),  64'(mPhase == 2));
            check("cyc_product", bus.product,    mProd);
        end
    end

    // Issue one multiply and hold it in EX until the result cycle has passed.
    task automatic runMul(input logic [31:0] a, input logic [31:0] b,
                          output logic [63:0] prod, output int lat, output int doneCyc);
        int n;
        bus.ex_valid = 1'b1;
        bus.alu_op   = MUL_OP;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.flush    = 1'b0;
        n   = 0;
        lat = -1;
        doneCyc = 0;
        while (n < 100) begin
            @(posedge clk);
            n++;
            #1;
            if (bus.done) begin
                lat = n - 1;
                doneCyc = cyc;
                break;
            end
        end
        if (lat < 0) check("done_timeout", 64'(1), 64'(0));
        prod = bus.product;
        @(posedge clk);
        #1;
        bus.ex_valid = 1'b0;
    endtask

    initial begin
        logic [63:0] prod;
        logic [63:0] prod2;
        int          lat;
        int          dc1;
        int          dc2;
        int          seen;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] corner [5];

        corner[0] = 32'h0000_0000;
        corner[1] = 32'h8000_0000;
        corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h0000_0001;
        corner[4] = 32'h7FFF_FFFF;

        rst          = 1'b0;
        bus.ex_valid = 1'b0;
        bus.alu_op   = 3'b000;
        bus.op_a     = '0;
        bus.op_b     = '0;
        bus.flush    = 1'b0;
        #2 rst = 1'b1;
        #13;
        check("rst_busy",    64'(bus.busy),  64'(0));
        check("rst_stall",   64'(bus.stall), 64'(0));
        check("rst_done",    64'(bus.done),  64'(0));
        check("rst_product", bus.product,    64'(0));
        #8 rst = 1'b0;
        @(posedge clk);
        #1;

        // Non-multiply traffic in IDLE must never stall.
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            bus.ex_valid = 1'($urandom_range(0, 1));
            do bus.alu_op = 3'($urandom_range(0, 7)); while (bus.alu_op == MUL_OP);
            bus.op_a = $urandom;
            bus.op_b = $urandom;
            @(negedge clk);
            if (bus.stall || bus.busy) seen++;
            @(posedge clk);
            #1;
        end
        check("nonmul_stall_seen", 64'(seen), 64'(0));
        bus.ex_valid = 1'b0;

        runMul(32'd3, 32'd5, prod, lat, dc1);
        check("mul3x5_latency", 64'(lat), 64'(32));
        check("mul3x5_product", prod, 64'h0000_0000_0000_000F);

        // Flush once the step counter has reached 10.
        bus.ex_valid = 1'b1;
        bus.alu_op   = MUL_OP;
        bus.op_a     = 32'd1234;
        bus.op_b     = 32'd77;
        repeat (11) @(posedge clk);
        #1;
        check("flush_busy_before", 64'(bus.busy), 64'(1));
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.ex_valid = 1'b0;
        check("flush_busy_after", 64'(bus.busy), 64'(0));
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        check("flush_done_count", 64'(seen), 64'(0));
        check("flush_product_kept", bus.product, 64'h0000_0000_0000_000F);
        @(posedge clk);
        #1;

        runMul(-32'sd7, 32'd6, prod, lat, dc1);
        check("mul_m7x6", prod, 64'hFFFF_FFFF_FFFF_FFD6);
        runMul(32'h8000_0000, 32'h8000_0000, prod, lat, dc1);
        check("mul_min_min", prod, 64'h4000_0000_0000_0000);
        runMul(32'h8000_0000, 32'hFFFF_FFFF, prod, lat, dc1);
        check("mul_min_m1", prod, 64'h0000_0000_8000_0000);

        runMul(32'd12, -32'sd3, prod, lat, dc1);
        runMul(32'd0, 32'h1234_5678, prod2, lat, dc2);
        check("b2b_first",  prod,  64'hFFFF_FFFF_FFFF_FFDC);
        check("b2b_second", prod2, 64'h0000_0000_0000_0000);
        check("b2b_gap", 64'(dc2 - dc1), 64'(34));

        // Asynchronous reset between edges while multiplying.
        runMul(32'd9, 32'd9, prod, lat, dc1);
        bus.ex_valid = 1'b1;
        bus.alu_op   = MUL_OP;
        bus.op_a     = 32'd100;
        bus.op_b     = 32'd200;
        repeat (6) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("midrst_busy",    64'(bus.busy),  64'(0));
        check("midrst_stall",   64'(bus.stall), 64'(0));
        check("midrst_done",    64'(bus.done),  64'(0));
        check("midrst_product", bus.product,    64'(0));
        bus.ex_valid = 1'b0;
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 1000; i++) begin
            a = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 7) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
            runMul(a, b, prod, lat, dc1);
            check("rand_product", prod, 64'(longint'(signed'(a)) * longint'(signed'(b))));
            check("rand_latency", 64'(lat), 64'(32));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
